// File: rtl/aes_128_stream_loader_if.sv
// Stream-side and core-side signal bundle for the AES-128 stream loader.
// The loader takes the slave view; a feeder/consumer/core model takes the master view.
interface aes_128_stream_loader_if;
   logic          in_valid;
   logic          in_ready;
   logic          in_kw;
   logic [31:0]   in_data;
   logic [127:0]  aes_state;
   logic [127:0]  aes_key;
   logic [127:0]  aes_out;
   logic          ct_valid;
   logic          ct_ready;
   logic [127:0]  ct_data;
   logic          key_ok;
   logic          err;

   modport slave (
      input  in_valid, in_kw, in_data, aes_out, ct_ready,
      output in_ready, aes_state, aes_key, ct_valid, ct_data, key_ok, err
   );

   modport master (
      output in_valid, in_kw, in_data, aes_out, ct_ready,
      input  in_ready, aes_state, aes_key, ct_valid, ct_data, key_ok, err
   );
endinterface

// File: rtl/aes_128_stream_loader.sv
// Feeds a pipelined, stall-free AES-128 core from a 32-bit word stream and collects
// its ciphertext into a small FIFO. A credit counter reserves a FIFO slot for every
// launched block, so the core output can always be captured without backpressure.
module aes_128_stream_loader #(
   parameter int LATENCY    = 20,
   parameter int OBUF_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   aes_128_stream_loader_if.slave  bus
);
   localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic                run;
   logic [1:0]          key_cnt;
   logic [1:0]          pt_cnt;
   logic [95:0]         key_sr;
   logic [95:0]         pt_sr;
   logic [127:0]        key_q;
   logic [127:0]        state_q;
   logic                key_ok_q;
   logic                err_q;
   logic                issue;
   logic [LATENCY-1:0]  vpipe;
   logic [LATENCY:0]    vnext;
   logic [127:0]        mem [OBUF_DEPTH];
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [CW-1:0]       count;
   logic [CW-1:0]       credits;

   logic stall, accept, key_acc, pt_acc, pt_last, push, pop;

   // Only the word that would launch a block can be held off: it needs a key and a FIFO credit.
   assign stall   = ~bus.in_kw && (pt_cnt == 2'd3) && (!key_ok_q || credits == '0);
   assign accept  = bus.in_valid && run && !stall;
   assign key_acc = accept && bus.in_kw;
   assign pt_acc  = accept && !bus.in_kw;
   assign pt_last = pt_acc && (pt_cnt == 2'd3);
   assign vnext   = {vpipe, issue};
   assign push    = vpipe[LATENCY-1];
   assign pop     = (count != '0) && bus.ct_ready;

   assign bus.in_ready  = run && !stall;
   assign bus.aes_state = state_q;
   assign bus.aes_key   = key_q;
   assign bus.key_ok    = key_ok_q;
   assign bus.err       = err_q;
   assign bus.ct_valid  = (count != '0);
   assign bus.ct_data   = mem[rd_ptr];

   // Input acceptance is held off until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   // Key assembly; the core key only moves on the edge that completes a full key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_cnt  <= 2'd0;
         key_sr   <= '0;
         key_q    <= '0;
         key_ok_q <= 1'b0;
      end else if (key_acc) begin
         key_sr <= {key_sr[63:0], bus.in_data};
         if (key_cnt == 2'd3) begin
            key_q    <= {key_sr, bus.in_data};
            key_ok_q <= 1'b1;
            key_cnt  <= 2'd0;
         end else begin
            key_cnt <= key_cnt + 2'd1;
         end
      end
   end

   // Plaintext assembly and block launch; a key word mid-block discards the partial block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pt_cnt  <= 2'd0;
         pt_sr   <= '0;
         state_q <= '0;
         issue   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         issue <= pt_last;
         if (key_acc && pt_cnt != 2'd0) begin
            pt_cnt <= 2'd0;
            err_q  <= 1'b1;
         end else if (pt_acc) begin
            pt_sr <= {pt_sr[63:0], bus.in_data};
            if (pt_cnt == 2'd3) begin
               state_q <= {pt_sr, bus.in_data};
               pt_cnt  <= 2'd0;
            end else begin
               pt_cnt <= pt_cnt + 2'd1;
            end
         end
      end
   end

   // Credits: one FIFO slot is claimed at launch and returned when the consumer pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CW'(OBUF_DEPTH);
      end else begin
         case ({pt_last, pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   // Launch marker delayed by exactly the core latency to find the matching core output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vpipe <= '0;
      else        vpipe <= vnext[LATENCY-1:0];
   end

   // Ciphertext FIFO; the head entry drives ct_data directly from storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.aes_out;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && count == CW'(OBUF_DEPTH)));

   a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
      credits <= CW'(OBUF_DEPTH));
endmodule
